// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and state encoding for the pipeline execution controller.
package pipe_ctrl_pkg;

    localparam int          DATA_LEN_DEF   = 32;
    localparam int          STAGES_DEF     = 4;
    localparam logic [31:0] HALT_INSTR_DEF = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP_INSTR      = 32'h0000_0000;

    // State encoding; IDLE is zero so a reset register file reads all-zero.
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_RUN       = 3'd1;
    localparam logic [2:0] ST_STEP_WAIT = 3'd2;
    localparam logic [2:0] ST_STEP_EXEC = 3'd3;
    localparam logic [2:0] ST_DRAIN     = 3'd4;
    localparam logic [2:0] ST_HALTED    = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE      = ST_IDLE,
        S_RUN       = ST_RUN,
        S_STEP_WAIT = ST_STEP_WAIT,
        S_STEP_EXEC = ST_STEP_EXEC,
        S_DRAIN     = ST_DRAIN,
        S_HALTED    = ST_HALTED
    } exec_state_e;

endpackage

// File: rtl/is_nop.sv
// Flags an instruction word that is the all-zero NOP.
module is_nop
    import pipe_ctrl_pkg::*;
#(
    parameter int DATA_LEN = DATA_LEN_DEF
) (
    input  logic [DATA_LEN-1:0] i_instr,
    output logic                o_is_nop
);

    // Pure compare against the NOP encoding.
    assign o_is_nop = (i_instr == DATA_LEN'(NOP_INSTR));

endmodule

// File: rtl/pipeline_exec_ctrl.sv
// Execution controller: sequences PC / pipeline-register enables in continuous
// or single-step mode, catches HALT at fetch and drains the pipeline to NOPs.
//
// Handshake note: i_start, i_step and i_abort are level-sampled pulses on the
// rising clock edge; there is no ready/acknowledge. A command is consumed only
// in the state that honours it and is silently dropped everywhere else.
module pipeline_exec_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int                  DATA_LEN   = DATA_LEN_DEF,
    parameter int                  STAGES     = STAGES_DEF,
    parameter logic [DATA_LEN-1:0] HALT_INSTR = HALT_INSTR_DEF
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_start,
    input  logic                         i_step_mode,
    input  logic                         i_step,
    input  logic                         i_abort,
    input  logic [DATA_LEN-1:0]          i_if_instr,
    input  logic [STAGES*DATA_LEN-1:0]   i_stage_instr,
    output logic                         o_pc_en,
    output logic                         o_pipe_en,
    output logic                         o_insert_nop,
    output logic                         o_running,
    output logic                         o_halted,
    output logic                         o_step_done,
    output logic [31:0]                  o_cycle_count,
    output logic [2:0]                   o_dbg_state
);

    localparam int DCW = $clog2(STAGES + 1);

    exec_state_e       state;
    exec_state_e       state_next;
    logic [DCW-1:0]    drain_cnt;
    logic [DCW-1:0]    drain_cnt_inc;
    logic [STAGES-1:0] stage_nop;
    logic              all_nop;
    logic              halt_hit;
    logic              drain_done;

    // One NOP detector per monitored pipeline register.
    for (genvar g = 0; g < STAGES; g++) begin : g_nop
        is_nop #(
            .DATA_LEN (DATA_LEN)
        ) u_is_nop (
            .i_instr  (i_stage_instr[g*DATA_LEN +: DATA_LEN]),
            .o_is_nop (stage_nop[g])
        );
    end

    assign all_nop       = &stage_nop;
    assign drain_cnt_inc = drain_cnt + DCW'(1);
    assign o_dbg_state   = state;

    // Next-state and output decode; abort overrides everything last.
    always_comb begin
        state_next   = state;
        o_pc_en      = 1'b0;
        o_pipe_en    = 1'b0;
        o_insert_nop = 1'b0;
        o_halted     = 1'b0;
        halt_hit     = ((state == S_RUN) || (state == S_STEP_EXEC)) &&
                       (i_if_instr == HALT_INSTR);
        // Watchdog fires on the edge at which the counter would reach STAGES.
        drain_done   = all_nop || (drain_cnt_inc == DCW'(STAGES));
        o_running    = (state == S_RUN) || (state == S_STEP_WAIT) ||
                       (state == S_STEP_EXEC) || (state == S_DRAIN);

        case (state)
            S_IDLE: begin
                if (i_start) begin
                    state_next = i_step_mode ? S_STEP_WAIT : S_RUN;
                end
            end
            S_RUN: begin
                o_pipe_en = 1'b1;
                if (halt_hit) begin
                    // PC holds on the HALT word, which is replaced by a NOP.
                    o_insert_nop = 1'b1;
                    state_next   = S_DRAIN;
                end else begin
                    o_pc_en = 1'b1;
                end
            end
            S_STEP_WAIT: begin
                if (i_step) begin
                    state_next = S_STEP_EXEC;
                end
            end
            S_STEP_EXEC: begin
                o_pipe_en = 1'b1;
                if (halt_hit) begin
                    o_insert_nop = 1'b1;
                    state_next   = S_DRAIN;
                end else begin
                    o_pc_en    = 1'b1;
                    state_next = S_STEP_WAIT;
                end
            end
            S_DRAIN: begin
                // Free-running regardless of how execution was started.
                o_pipe_en    = 1'b1;
                o_insert_nop = 1'b1;
                if (drain_done) begin
                    state_next = S_HALTED;
                end
            end
            S_HALTED: begin
                o_halted = 1'b1;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        if (i_abort) begin
            state_next   = S_IDLE;
            o_pc_en      = 1'b0;
            o_pipe_en    = 1'b0;
            o_insert_nop = 1'b0;
        end
    end

    // State, drain counter, advance counter and registered step-done pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= S_IDLE;
            drain_cnt     <= '0;
            o_cycle_count <= '0;
            o_step_done   <= 1'b0;
        end else begin
            state       <= state_next;
            drain_cnt   <= (state == S_DRAIN) ? drain_cnt_inc : '0;
            o_step_done <= (state == S_STEP_EXEC) && !i_abort;
            if ((state == S_IDLE) && i_start && !i_abort) begin
                o_cycle_count <= '0;
            end else if (o_pipe_en && (o_cycle_count != 32'hFFFF_FFFF)) begin
                o_cycle_count <= o_cycle_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_exec_ctrl.sv
// Testbench for pipeline_exec_ctrl: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a behavioural model.
module tb_pipeline_exec_ctrl;

    localparam int          DATA_LEN = 32;
    localparam int          STAGES   = 4;
    localparam logic [31:0] HALT     = 32'hFFFF_FFFF;
    localparam logic [31:0] ADDI     = 32'h2001_0005;

    logic                       clk;
    logic                       rst_n;
    logic                       start;
    logic                       step_mode;
    logic                       step;
    logic                       abort;
    logic [DATA_LEN-1:0]        if_instr;
    logic [STAGES*DATA_LEN-1:0] stage_instr;
    logic                       pc_en;
    logic                       pipe_en;
    logic                       insert_nop;
    logic                       running;
    logic                       halted;
    logic                       step_done;
    logic [31:0]                cycle_count;
    logic [2:0]                 dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    pipeline_exec_ctrl #(
        .DATA_LEN   (DATA_LEN),
        .STAGES     (STAGES),
        .HALT_INSTR (HALT)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_start       (start),
        .i_step_mode   (step_mode),
        .i_step        (step),
        .i_abort       (abort),
        .i_if_instr    (if_instr),
        .i_stage_instr (stage_instr),
        .o_pc_en       (pc_en),
        .o_pipe_en     (pipe_en),
        .o_insert_nop  (insert_nop),
        .o_running     (running),
        .o_halted      (halted),
        .o_step_done   (step_done),
        .o_cycle_count (cycle_count),
        .o_dbg_state   (dbg_state)
    );

    // Clock and safety timeout.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running=%0b, expected completion", running);
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        start;
        logic        mode;
        logic        step;
        logic        abort;
        logic [31:0] instr;
        logic [127:0] stage;
        logic        pc;
        logic        pipe;
        logic        nop;
        logic        run;
        logic        halt;
        logic        done;
        logic [31:0] count;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic s, input logic m, input logic st, input logic ab,
                         input logic [31:0] ins, input logic [127:0] stg);
        start       = s;
        step_mode   = m;
        step        = st;
        abort       = ab;
        if_instr    = ins;
        stage_instr = stg;
    endtask

    // Drive inputs just after the falling edge, settle, then sample.
    task automatic next_cycle(input logic s, input logic m, input logic st, input logic ab,
                              input logic [31:0] ins, input logic [127:0] stg);
        @(negedge clk);
        drive(s, m, st, ab, ins, stg);
        #1;
    endtask

    task automatic check_outputs(input string name, input logic e_pc, input logic e_pipe,
                                 input logic e_nop, input logic e_run, input logic e_halt,
                                 input logic e_done, input logic [31:0] e_count);
        chk({name, ".pc_en"},       pc_en,       e_pc);
        chk({name, ".pipe_en"},     pipe_en,     e_pipe);
        chk({name, ".insert_nop"},  insert_nop,  e_nop);
        chk({name, ".running"},     running,     e_run);
        chk({name, ".halted"},      halted,      e_halt);
        chk({name, ".step_done"},   step_done,   e_done);
        chk({name, ".cycle_count"}, cycle_count, e_count);
    endtask

    function automatic logic [127:0] mk_stage(input int zeros, input logic [31:0] base);
        logic [127:0] r;
        r = '0;
        for (int j = 0; j < STAGES; j++) begin
            r[j*32 +: 32] = (j < zeros) ? 32'h0 : base + 32'(j);
        end
        return r;
    endfunction

    task automatic add_vec(input logic s, input logic m, input logic st, input logic ab,
                           input logic [31:0] ins, input logic [127:0] stg,
                           input logic e_pc, input logic e_pipe, input logic e_nop,
                           input logic e_run, input logic e_halt, input logic e_done,
                           input logic [31:0] e_count);
        vec_t v;
        v.start = s;  v.mode = m;  v.step = st;  v.abort = ab;
        v.instr = ins; v.stage = stg;
        v.pc = e_pc; v.pipe = e_pipe; v.nop = e_nop; v.run = e_run;
        v.halt = e_halt; v.done = e_done; v.count = e_count;
        vecs.push_back(v);
    endtask

    // Count drain cycles after a HALT until HALTED, bounded.
    task automatic measure_drain(input logic [127:0] stg, output int drain_cycles);
        drain_cycles = 0;
        for (int i = 0; i < 10; i++) begin
            next_cycle(0, 0, 0, 0, HALT, stg);
            if (halted) break;
            if (running && pipe_en && insert_nop) drain_cycles++;
        end
    endtask

    // Behavioural reference model for the random phase.
    bit     m_busy, m_step, m_exec, m_drain, m_halted, m_done;
    int     m_dcyc;
    longint m_count;

    task automatic model_reset();
        m_busy = 0; m_step = 0; m_exec = 0; m_drain = 0; m_halted = 0; m_done = 0;
        m_dcyc = 0; m_count = 0;
    endtask

    initial begin
        int   drain_cycles;
        int   pc_pulses, done_pulses, pc_rises, overlap;
        logic prev_pc;

        drive(0, 0, 0, 0, ADDI, mk_stage(0, 32'h100));
        rst_n = 1'b0;
        #12;
        chk("reset.dbg_state", dbg_state, 3'd0);
        check_outputs("reset", 0, 0, 0, 0, 0, 0, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Continuous run, HALT with dirty stages shifting to NOP, HALTED.
        add_vec(1, 0, 0, 0, ADDI, mk_stage(0, 32'h100), 0, 0, 0, 0, 0, 0, 32'd0);
        for (int k = 1; k <= 10; k++)
            add_vec(0, 0, 0, 0, ADDI, mk_stage(0, 32'h100), 1, 1, 0, 1, 0, 0, 32'(k - 1));
        add_vec(0, 0, 0, 0, HALT, mk_stage(0, 32'h200), 0, 1, 1, 1, 0, 0, 32'd10);
        for (int k = 1; k <= 4; k++)
            add_vec(0, 0, 0, 0, HALT, mk_stage(k, 32'h200), 0, 1, 1, 1, 0, 0, 32'(10 + k));
        add_vec(1, 1, 1, 0, ADDI, mk_stage(4, 32'h0), 0, 0, 0, 0, 1, 0, 32'd15);
        add_vec(0, 0, 0, 0, ADDI, mk_stage(0, 32'h300), 0, 0, 0, 0, 1, 0, 32'd15);

        foreach (vecs[i]) begin
            next_cycle(vecs[i].start, vecs[i].mode, vecs[i].step, vecs[i].abort,
                       vecs[i].instr, vecs[i].stage);
            check_outputs($sformatf("vec%0d", i), vecs[i].pc, vecs[i].pipe, vecs[i].nop,
                          vecs[i].run, vecs[i].halt, vecs[i].done, vecs[i].count);
        end

        // Abort out of HALTED keeps the count.
        next_cycle(0, 0, 0, 1, ADDI, mk_stage(0, 32'h100));
        check_outputs("abort_halted", 0, 0, 0, 0, 1, 0, 32'd15);
        next_cycle(0, 0, 0, 0, ADDI, mk_stage(0, 32'h100));
        check_outputs("after_abort_halted", 0, 0, 0, 0, 0, 0, 32'd15);

        // Single-step: three pulses, one held high for two cycles.
        next_cycle(1, 1, 0, 0, ADDI, mk_stage(0, 32'h100));
        pc_pulses = 0; done_pulses = 0; pc_rises = 0; overlap = 0; prev_pc = 0;
        for (int i = 0; i < 20; i++) begin
            next_cycle(0, 0, (i == 2 || i == 7 || i == 8 || i == 12), 0, ADDI, mk_stage(0, 32'h100));
            if (pc_en) pc_pulses++;
            if (pc_en && !prev_pc) pc_rises++;
            if (step_done) done_pulses++;
            if (step_done && pipe_en) overlap++;
            prev_pc = pc_en;
        end
        chk("step.pc_high_cycles", pc_pulses, 3);
        chk("step.pc_rises", pc_rises, 3);
        chk("step.done_pulses", done_pulses, 3);
        chk("step.done_in_wait", overlap, 0);
        chk("step.cycle_count", cycle_count, 32'd3);

        // Abort together with step in STEP_WAIT.
        next_cycle(0, 0, 1, 1, ADDI, mk_stage(0, 32'h100));
        chk("abort_wait.pc_en", pc_en, 0);
        chk("abort_wait.pipe_en", pipe_en, 0);
        next_cycle(0, 0, 0, 0, ADDI, mk_stage(0, 32'h100));
        check_outputs("abort_wait.idle", 0, 0, 0, 0, 0, 0, 32'd3);
        next_cycle(1, 0, 0, 0, ADDI, mk_stage(0, 32'h100));
        chk("restart.count_kept", cycle_count, 32'd3);
        next_cycle(0, 0, 0, 0, ADDI, mk_stage(0, 32'h100));
        check_outputs("restart.cleared", 1, 1, 0, 1, 0, 0, 32'd0);
        next_cycle(0, 0, 0, 0, ADDI, mk_stage(0, 32'h100));
        chk("restart.count1", cycle_count, 32'd1);

        // Drain watchdog with stages stuck non-NOP.
        next_cycle(0, 0, 0, 0, HALT, {4{32'h1}});
        check_outputs("wd.halt_cycle", 0, 1, 1, 1, 0, 0, 32'd2);
        measure_drain({4{32'h1}}, drain_cycles);
        chk("wd.drain_cycles", drain_cycles, 4);
        chk("wd.halted", halted, 1);
        chk("wd.count", cycle_count, 32'd7);

        // DRAIN entered with all stages already NOP lasts one cycle.
        next_cycle(0, 0, 0, 1, ADDI, '0);
        next_cycle(1, 0, 0, 0, ADDI, '0);
        next_cycle(0, 0, 0, 0, HALT, '0);
        check_outputs("early.halt_cycle", 0, 1, 1, 1, 0, 0, 32'd0);
        measure_drain('0, drain_cycles);
        chk("early.drain_cycles", drain_cycles, 1);
        chk("early.halted", halted, 1);

        // Abort during DRAIN.
        next_cycle(0, 0, 0, 1, ADDI, mk_stage(0, 32'h400));
        next_cycle(1, 0, 0, 0, ADDI, mk_stage(0, 32'h400));
        next_cycle(0, 0, 0, 0, ADDI, mk_stage(0, 32'h400));
        next_cycle(0, 0, 0, 0, HALT, mk_stage(0, 32'h400));
        next_cycle(0, 0, 0, 1, HALT, mk_stage(0, 32'h400));
        check_outputs("abort_drain", 0, 0, 0, 1, 0, 0, 32'd2);
        next_cycle(0, 0, 0, 0, ADDI, mk_stage(0, 32'h400));
        check_outputs("abort_drain.idle", 0, 0, 0, 0, 0, 0, 32'd2);

        // Asynchronous reset in the middle of DRAIN.
        next_cycle(1, 0, 0, 0, ADDI, mk_stage(0, 32'h500));
        next_cycle(0, 0, 0, 0, ADDI, mk_stage(0, 32'h500));
        next_cycle(0, 0, 0, 0, HALT, mk_stage(0, 32'h500));
        next_cycle(0, 0, 0, 0, HALT, mk_stage(0, 32'h500));
        check_outputs("rst_drain.before", 0, 1, 1, 1, 0, 0, 32'd2);
        rst_n = 1'b0;
        #1;
        check_outputs("rst_drain.async", 0, 0, 0, 0, 0, 0, 32'd0);
        chk("rst_drain.dbg_state", dbg_state, 3'd0);
        #2;
        rst_n = 1'b1;
        next_cycle(0, 0, 1, 0, ADDI, mk_stage(0, 32'h500));
        next_cycle(0, 0, 1, 0, ADDI, mk_stage(0, 32'h500));
        check_outputs("rst_drain.step_ignored", 0, 0, 0, 0, 0, 0, 32'd0);
        next_cycle(0, 0, 0, 0, ADDI, mk_stage(0, 32'h500));
        check_outputs("rst_drain.still_idle", 0, 0, 0, 0, 0, 0, 32'd0);

        // Randomized run against the behavioural model.
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            logic        r_start, r_mode, r_step, r_abort;
            logic [31:0] r_instr;
            logic [127:0] r_stage;
            bit fetching, hit, e_pipe, e_pc, e_nop, nd;

            r_start = ($urandom_range(0, 5) == 0);
            r_mode  = 1'($urandom_range(0, 1));
            r_step  = ($urandom_range(0, 2) == 0);
            r_abort = ($urandom_range(0, 39) == 0);
            r_instr = ($urandom_range(0, 15) == 0) ? HALT : $urandom;
            if (r_instr == HALT && $urandom_range(0, 15) != 0) r_instr = HALT;
            r_stage = '0;
            for (int j = 0; j < STAGES; j++)
                if ($urandom_range(0, 3) == 0) r_stage[j*32 +: 32] = $urandom;

            next_cycle(r_start, r_mode, r_step, r_abort, r_instr, r_stage);

            fetching = m_busy && !m_drain && (!m_step || m_exec);
            hit      = fetching && (r_instr == HALT);
            e_pipe   = !r_abort && (fetching || m_drain);
            e_pc     = !r_abort && fetching && !hit;
            e_nop    = !r_abort && (hit || m_drain);
            check_outputs($sformatf("rand%0d", n), e_pc, e_pipe, e_nop, m_busy, m_halted,
                          m_done, m_count[31:0]);

            @(posedge clk);
            nd = m_exec && !r_abort;
            if (e_pipe && m_count != 64'hFFFF_FFFF) m_count++;
            if (r_abort) begin
                m_busy = 0; m_step = 0; m_exec = 0; m_drain = 0; m_halted = 0;
            end else if (!m_busy && !m_halted) begin
                if (r_start) begin
                    m_busy = 1; m_step = r_mode; m_exec = 0; m_count = 0;
                end
            end else if (hit) begin
                m_drain = 1; m_dcyc = 0; m_exec = 0;
            end else if (m_drain) begin
                m_dcyc++;
                if (r_stage == '0 || m_dcyc == STAGES) begin
                    m_drain = 0; m_busy = 0; m_step = 0; m_halted = 1;
                end
            end else if (m_busy && m_step) begin
                if (m_exec) m_exec = 0;
                else if (r_step) m_exec = 1;
            end
            m_done = nd;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_exec_ctrl.md
# pipeline_exec_ctrl

Execution controller for the MIPS32 pipeline. Sequences the PC and pipeline-register enables in continuous or single-step mode, detects the HALT instruction at fetch, and drains the pipeline until every stage register holds a NOP. It sits between the debug unit (start/step/abort commands) and the datapath (PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers).

## Interface
- DATA_LEN, 32, instruction width
- STAGES, 4, number of pipeline registers monitored for the drain
- HALT_INSTR, 32'hFFFF_FFFF, instruction word that ends execution

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  reset, asynchronous and active-low
- i_start  in  1  pulse; honoured only in IDLE
- i_step_mode  in  1  sampled with i_start: 1 selects single-step, 0 selects continuous
- i_step  in  1  pulse; advances one cycle in STEP_WAIT
- i_abort  in  1  return to IDLE; highest priority
- i_if_instr  in  DATA_LEN  instruction fetched this cycle
- i_stage_instr  in  STAGES*DATA_LEN  instructions held in the pipeline registers; stage 0 is in the LSBs
- o_pc_en  out  1  PC write enable
- o_pipe_en  out  1  pipeline-register write enable
- o_insert_nop  out  1  forces IF/ID to load 0 instead of i_if_instr
- o_running  out  1  high in RUN, STEP_WAIT, STEP_EXEC and DRAIN
- o_halted  out  1  high in HALTED
- o_step_done  out  1  one-cycle pulse after each executed step
- o_cycle_count  out  32  number of cycles in which the pipeline advanced

## Operation
- States: IDLE, RUN, STEP_WAIT, STEP_EXEC, DRAIN, HALTED.
- IDLE:
  - i_start=1 and i_step_mode=0 → RUN.
  - i_start=1 and i_step_mode=1 → STEP_WAIT.
  - On either start, o_cycle_count clears to 0.
- RUN: o_pipe_en=1 and o_pc_en=1 every cycle.
- STEP_WAIT: all enables 0. i_step=1 → STEP_EXEC.
- STEP_EXEC: lasts exactly one cycle with o_pipe_en=1 and o_pc_en=1, then → STEP_WAIT.
- halt_hit is combinational: (state is RUN or STEP_EXEC) and i_if_instr == HALT_INSTR.
  - While halt_hit=1: o_pc_en=0 (PC holds on HALT), o_insert_nop=1, o_pipe_en stays 1.
  - Next state is DRAIN. The HALT word never enters IF/ID.
- DRAIN: runs free even if started in step mode.
  - o_pipe_en=1, o_pc_en=0, o_insert_nop=1.
  - A drain counter (width clog2(STAGES+1)) increments each cycle.
  - → HALTED when every stage word is NOP (all-zero, via is_nop), or when the drain counter reaches STAGES (watchdog), whichever comes first.
- HALTED: all enables 0 and o_halted=1. Leaves only on i_abort.
- i_abort=1 in any state → IDLE on the next edge.
  - In the cycle i_abort is high, o_pc_en, o_pipe_en and o_insert_nop are forced to 0.
  - o_cycle_count is retained until the next i_start.
- Ignored inputs:
  - i_start outside IDLE.
  - i_step outside STEP_WAIT, including i_step held high during STEP_EXEC.
  - i_step_mode outside the i_start cycle.
- o_cycle_count increments on each edge where o_pipe_en=1, and saturates at 32'hFFFF_FFFF.

## Timing
- Reset (i_rst_n=0, asynchronous): state=IDLE, o_cycle_count=0, drain counter=0, o_step_done=0. All outputs read 0.
- i_start at edge N: enables are high in the cycle after edge N (RUN) or the FSM waits (STEP_WAIT).
- i_step sampled at edge N: STEP_EXEC occupies cycle N+1, and o_step_done is high in cycle N+2, coinciding with STEP_WAIT.
- o_step_done is registered. All other outputs are decoded from state, plus halt_hit and i_abort as described above.
- HALT fetched in cycle C: DRAIN spans cycles C+1 onward. HALTED is reached at most STAGES+1 cycles after C.
- If DRAIN is entered with all stages already NOP, it still lasts 1 cycle (NOP check is evaluated in DRAIN only).
- Reset deasserted mid-run: the FSM restarts in IDLE and needs a new i_start.

## Structure
- Shared package `pipe_ctrl_pkg`: state encoding localparams, HALT_INSTR default, and a `NOP_INSTR` = 0 constant.
- STAGES instances of the existing `is_nop` sub-module, one per stage slice. AND-reduce their o_is_nop outputs to get all_nop.
- Single always block for state, drain counter, cycle counter and o_step_done. Output decode is combinational.

## Test plan
- Continuous run:
  - Stimulus: i_start with mode 0; i_if_instr = 0x2001_0005 for 10 cycles.
  - Required: o_pc_en=o_pipe_en=1 throughout; o_cycle_count=10; o_halted=0.
- HALT with dirty stages:
  - Stimulus: HALT fetched in RUN; stage words non-zero and shifting to zero one per cycle.
  - Required in HALT cycle: o_pc_en=0, o_insert_nop=1, o_pipe_en=1.
  - Required after: HALTED after 4 DRAIN cycles; o_halted=1; o_cycle_count includes the drain cycles.
- Step mode:
  - Stimulus: i_start with mode 1, then 3 i_step pulses 5 cycles apart, with i_step held high 2 cycles on one of them.
  - Required: exactly 3 single-cycle enable pulses; 3 o_step_done pulses; o_cycle_count=3.
- Drain watchdog:
  - Stimulus: HALT fetched; stage words stuck at 0x0000_0001.
  - Required: HALTED after exactly STAGES=4 drain cycles.
- Abort priority:
  - Stimulus: i_abort and i_step together in STEP_WAIT; separately, i_abort during DRAIN.
  - Required: enables 0 in the abort cycle; IDLE next edge; o_cycle_count unchanged until the next i_start clears it.
- Async reset mid-DRAIN:
  - Stimulus: i_rst_n low for half a cycle during DRAIN.
  - Required: outputs go to 0 immediately, without waiting for a clock edge; o_cycle_count=0; i_step ignored until a new i_start.
